sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
Two-port arbiter that shares one single-port RAM instance (1-cycle read latency, byte-enabled writes) between a data master (port 0) and an instruction master (port 1). Port 0 has fixed priority. Port 1 has a starvation guard that forces a port-1 grant after a bounded wait. The block drives the RAM enable/address/write bus and returns read data with a response-valid pulse to whichever port issued the access.

Parameters:
ADDR_WIDTH, 15, byte address width of RAM (32 KiB default)
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
STARVE_LIMIT, 4, consecutive denied cycles after which port 1 takes priority; legal range >=1

Ports:
clk  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
p0_req_i  in  1  port 0 request
p0_gnt_o  out  1  port 0 grant (combinational, same cycle)
p0_addr_i  in  ADDR_WIDTH  port 0 address
p0_we_i  in  1  port 0 write enable
p0_be_i  in  DATA_WIDTH/8  port 0 byte enables
p0_wdata_i  in  DATA_WIDTH  port 0 write data
p0_rvalid_o  out  1  port 0 response valid
p0_rdata_o  out  DATA_WIDTH  port 0 read data
p1_req_i / p1_gnt_o / p1_addr_i / p1_we_i / p1_be_i / p1_wdata_i / p1_rvalid_o / p1_rdata_o  as port 0
ram_en_o  out  1  RAM enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_we_o  out  1  RAM write enable
ram_be_o  out  DATA_WIDTH/8  RAM byte enables
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o

Behaviour:
- Reset (async assert, sync release): starve_cnt=0, rvalid_q=0, resp_sel_q=0. All *_rvalid_o=0, *_rdata_o=0. Grants and RAM outputs are combinational, so they are 0 while no request is present.
- Arbitration each cycle (combinational):
  - prio1 = (starve_cnt == STARVE_LIMIT).
  - p1_gnt = p1_req & (~p0_req | prio1).
  - p0_gnt = p0_req & ~p1_gnt.
  - At most one grant per cycle.
- RAM drive:
  - ram_en_o = p0_gnt | p1_gnt.
  - addr/we/be/wdata are muxed from the granted port.
  - When no port is granted: ram_en_o=0, ram_we_o=0, ram_be_o=0, addr/wdata=0.
  - ram_we_o is never asserted without ram_en_o.
- Starvation counter (registered, width $clog2(STARVE_LIMIT+1)):
  - If p1_req & ~p1_gnt: increment, saturating at STARVE_LIMIT.
  - Otherwise (granted or not requesting): clear to 0.
  - Worst-case port-1 wait under continuous port-0 traffic is STARVE_LIMIT cycles; it is granted on cycle STARVE_LIMIT+1.
- Response pipeline:
  - rvalid_q <= ram_en_o; resp_sel_q <= p1_gnt.
  - pX_rvalid_o = rvalid_q & (resp_sel_q==X), exactly one cycle after pX's grant, for both reads and writes.
  - pX_rdata_o = ram_rdata_i when pX_rvalid_o, else 0. Write responses carry don't-care data from the RAM; masters ignore it.
- Back-to-back: a grant every cycle is legal. Throughput is one access per cycle; responses arrive in grant order.
- Request protocol:
  - A master holds req and its address/write fields stable until it is granted.
  - The arbiter does not latch ungranted requests.
  - Dropping req before grant is allowed; port 1 dropping its req clears starve_cnt.
- Reset mid-operation: an in-flight response is discarded (rvalid_q cleared asynchronously) and starve_cnt returns to 0. RAM contents are unaffected by this block.

Test Plan:
- Single read: p0 reads addr 0x0010 holding 0xDEADBEEF -> p0_gnt=1 same cycle, ram_en_o=1, ram_addr_o=0x0010; next cycle p0_rvalid_o=1, p0_rdata_o=0xDEADBEEF, p1_rvalid_o=0.
- Byte write then read: p1 writes 0x11223344 to 0x0020 with be=4'b0100, then reads 0x0020 (prior content 0) -> ram_be_o=4'b0100 on the write, write ack on p1_rvalid_o, read returns 0x00220000.
- Simultaneous requests: p0 and p1 both request for one cycle, starve_cnt=0 -> p0 granted, p1 not; p1 granted the following cycle; responses arrive on p0 then p1 in consecutive cycles.
- Starvation: p0 requests continuously, p1 requests continuously, STARVE_LIMIT=4 -> p1 denied cycles 1-4, starve_cnt reaches 4, p1 granted cycle 5 with p0_gnt=0 that cycle, then starve_cnt=0 and p0 is granted cycle 6.
- Idle: no requests for 10 cycles -> ram_en_o=0, ram_we_o=0, no rvalid pulses, starve_cnt stays 0.
- Reset mid-operation: assert rst_i the cycle after a p0 read grant -> p0_rvalid_o forced 0 immediately, no response after release; starve_cnt=0 even if it was 3 before reset.

Source files
------------

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  p0_req_i;
    logic                  p0_gnt_o;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic                  p0_we_i;
    logic [BE_WIDTH-1:0]   p0_be_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic                  p0_rvalid_o;
    logic [DATA_WIDTH-1:0] p0_rdata_o;

    logic                  p1_req_i;
    logic                  p1_gnt_o;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic                  p1_we_i;
    logic [BE_WIDTH-1:0]   p1_be_i;
    logic [DATA_WIDTH-1:0] p1_wdata_i;
    logic                  p1_rvalid_o;
    logic [DATA_WIDTH-1:0] p1_rdata_o;

    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_we_o;
    logic [BE_WIDTH-1:0]   ram_be_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between a fixed-priority data port (p0) and an
// instruction port (p1) whose starvation guard forces a grant after STARVE_LIMIT denials.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst_i,
    sp_ram_arbiter_if.slave     bus
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 prio1;
    logic                 p0_gnt;
    logic                 p1_gnt;
    logic                 rvalid_q;
    logic                 resp_sel_q;

    assign prio1  = (starve_cnt == CNT_MAX);
    assign p1_gnt = bus.p1_req_i & (~bus.p0_req_i | prio1);
    assign p0_gnt = bus.p0_req_i & ~p1_gnt;

    assign bus.p0_gnt_o = p0_gnt;
    assign bus.p1_gnt_o = p1_gnt;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = '0;
        bus.ram_wdata_o = '0;
        if (p1_gnt) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = bus.p1_addr_i;
            bus.ram_we_o    = bus.p1_we_i;
            bus.ram_be_o    = bus.p1_be_i;
            bus.ram_wdata_o = bus.p1_wdata_i;
        end else if (p0_gnt) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = bus.p0_addr_i;
            bus.ram_we_o    = bus.p0_we_i;
            bus.ram_be_o    = bus.p0_be_i;
            bus.ram_wdata_o = bus.p0_wdata_i;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (bus.p1_req_i & ~p1_gnt) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Response follows the grant by exactly the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q   <= 1'b0;
            resp_sel_q <= 1'b0;
        end else begin
            rvalid_q   <= p0_gnt | p1_gnt;
            resp_sel_q <= p1_gnt;
        end
    end

    assign bus.p0_rvalid_o = rvalid_q & ~resp_sel_q;
    assign bus.p1_rvalid_o = rvalid_q & resp_sel_q;
    assign bus.p0_rdata_o  = bus.p0_rvalid_o ? bus.ram_rdata_i : '0;
    assign bus.p1_rdata_o  = bus.p1_rvalid_o ? bus.ram_rdata_i : '0;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: a vector table for per-cycle arbitration and
// responses, plus hand sequences for reset, idle and mid-operation reset.
module tb_sp_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;

    logic clk;
    logic rst_i;
    int   total;
    int   bad;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency and byte enables.
    logic [DW-1:0] mem [0:(1<<(AW-2))-1];
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_be_o[b]) mem[bus.ram_addr_o[AW-1:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
                end
            end
            bus.ram_rdata_i <= mem[bus.ram_addr_o[AW-1:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [3:0]    b0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [3:0]    b1;
        logic [DW-1:0] d1;
        logic [1:0]    gnt;    // {p1, p0} expected grant
        int            starve; // expected starve count after the edge
        logic          chk;    // response data is meaningful (reads)
        logic [DW-1:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, input logic [AW-1:0] a0, input logic [3:0] b0,
                                input logic [DW-1:0] d0, input logic r1, w1, input logic [AW-1:0] a1,
                                input logic [3:0] b1, input logic [DW-1:0] d1, input logic [1:0] gnt,
                                input int starve, input logic chk, input logic [DW-1:0] rdata);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.gnt = gnt; v.starve = starve; v.chk = chk; v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1, input logic [AW-1:0] a1);
        bus.p0_req_i = r0; bus.p0_we_i = 1'b0; bus.p0_addr_i = a0; bus.p0_be_i = 4'hF; bus.p0_wdata_i = '0;
        bus.p1_req_i = r1; bus.p1_we_i = 1'b0; bus.p1_addr_i = a1; bus.p1_be_i = 4'hF; bus.p1_wdata_i = '0;
    endtask

    localparam logic [AW-1:0] A = 15'h0010;
    localparam logic [AW-1:0] B = 15'h0020;
    localparam logic [AW-1:0] C = 15'h0030;

    vec_t vecs [17];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = '0;
        mem[A[AW-1:2]] = 32'hDEADBEEF;
        bus.ram_rdata_i = '0;

        vecs[0]  = mk(1,0,A,4'hF,0,            0,0,0,4'h0,0,            2'b01,0,1,32'hDEADBEEF);
        vecs[1]  = mk(0,0,0,4'h0,0,            1,1,B,4'b0100,32'h11223344, 2'b10,0,0,0);
        vecs[2]  = mk(0,0,0,4'h0,0,            1,0,B,4'hF,0,            2'b10,0,1,32'h00220000);
        vecs[3]  = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,1,1,32'hDEADBEEF);
        vecs[4]  = mk(0,0,0,4'h0,0,            1,0,B,4'hF,0,            2'b10,0,1,32'h00220000);
        vecs[5]  = mk(0,0,0,4'h0,0,            0,0,0,4'h0,0,            2'b00,0,1,0);
        vecs[6]  = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,1,1,32'hDEADBEEF);
        vecs[7]  = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,2,1,32'hDEADBEEF);
        vecs[8]  = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,3,1,32'hDEADBEEF);
        vecs[9]  = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,4,1,32'hDEADBEEF);
        vecs[10] = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b10,0,1,32'h00220000);
        vecs[11] = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,1,1,32'hDEADBEEF);
        vecs[12] = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,2,1,32'hDEADBEEF);
        vecs[13] = mk(1,0,A,4'hF,0,            1,0,B,4'hF,0,            2'b01,3,1,32'hDEADBEEF);
        vecs[14] = mk(1,0,A,4'hF,0,            0,0,B,4'hF,0,            2'b01,0,1,32'hDEADBEEF);
        vecs[15] = mk(1,1,C,4'hF,32'hCAFEF00D, 0,0,0,4'h0,0,            2'b01,0,0,0);
        vecs[16] = mk(1,0,C,4'hF,0,            0,0,0,4'h0,0,            2'b01,0,1,32'hCAFEF00D);

        // Reset state
        rst_i = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_p0_rvalid", 32'(bus.p0_rvalid_o), 0);
        check("rst_p1_rvalid", 32'(bus.p1_rvalid_o), 0);
        check("rst_p0_rdata",  bus.p0_rdata_o, 0);
        check("rst_ram_en",    32'(bus.ram_en_o), 0);
        check("rst_starve",    32'(dut.starve_cnt), 0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 17; i++) begin
            logic          g0, g1;
            logic [AW-1:0] ea;
            logic [3:0]    eb;
            logic [DW-1:0] ed;
            logic          ew;
            @(negedge clk);
            bus.p0_req_i = vecs[i].r0; bus.p0_we_i = vecs[i].w0; bus.p0_addr_i = vecs[i].a0;
            bus.p0_be_i  = vecs[i].b0; bus.p0_wdata_i = vecs[i].d0;
            bus.p1_req_i = vecs[i].r1; bus.p1_we_i = vecs[i].w1; bus.p1_addr_i = vecs[i].a1;
            bus.p1_be_i  = vecs[i].b1; bus.p1_wdata_i = vecs[i].d1;
            g0 = vecs[i].gnt[0];
            g1 = vecs[i].gnt[1];
            ea = g1 ? vecs[i].a1 : (g0 ? vecs[i].a0 : '0);
            eb = g1 ? vecs[i].b1 : (g0 ? vecs[i].b0 : '0);
            ed = g1 ? vecs[i].d1 : (g0 ? vecs[i].d0 : '0);
            ew = g1 ? vecs[i].w1 : (g0 ? vecs[i].w0 : 1'b0);
            #1;
            check($sformatf("v%0d_p0_gnt", i), 32'(bus.p0_gnt_o), 32'(g0));
            check($sformatf("v%0d_p1_gnt", i), 32'(bus.p1_gnt_o), 32'(g1));
            check($sformatf("v%0d_ram_en", i), 32'(bus.ram_en_o), 32'(g0 | g1));
            check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr_o), 32'(ea));
            check($sformatf("v%0d_ram_we", i), 32'(bus.ram_we_o), 32'(ew));
            check($sformatf("v%0d_ram_be", i), 32'(bus.ram_be_o), 32'(eb));
            check($sformatf("v%0d_ram_wdata", i), bus.ram_wdata_o, ed);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_p0_rvalid", i), 32'(bus.p0_rvalid_o), 32'(g0));
            check($sformatf("v%0d_p1_rvalid", i), 32'(bus.p1_rvalid_o), 32'(g1));
            check($sformatf("v%0d_starve", i), 32'(dut.starve_cnt), 32'(vecs[i].starve));
            if (!g0) check($sformatf("v%0d_p0_rdata_zero", i), bus.p0_rdata_o, 0);
            if (!g1) check($sformatf("v%0d_p1_rdata_zero", i), bus.p1_rdata_o, 0);
            if (vecs[i].chk && g0) check($sformatf("v%0d_p0_rdata", i), bus.p0_rdata_o, vecs[i].rdata);
            if (vecs[i].chk && g1) check($sformatf("v%0d_p1_rdata", i), bus.p1_rdata_o, vecs[i].rdata);
        end

        // Idle for 10 cycles
        @(negedge clk);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("idle%0d_ram_en", i), 32'(bus.ram_en_o), 0);
            check($sformatf("idle%0d_ram_we", i), 32'(bus.ram_we_o), 0);
            @(posedge clk);
            #1;
            check($sformatf("idle%0d_rvalid", i), 32'({bus.p1_rvalid_o, bus.p0_rvalid_o}), 0);
            check($sformatf("idle%0d_starve", i), 32'(dut.starve_cnt), 0);
            @(negedge clk);
        end

        // Reset mid-operation: build starve count to 3 with a p0 read in flight
        drive(1, A, 1, B);
        repeat (3) @(posedge clk);
        #1;
        check("mid_p0_rvalid_before", 32'(bus.p0_rvalid_o), 1);
        check("mid_starve_before", 32'(dut.starve_cnt), 3);
        #1;
        rst_i = 1'b1;
        drive(0, 0, 0, 0);
        #1;
        check("mid_p0_rvalid_rst", 32'(bus.p0_rvalid_o), 0);
        check("mid_p0_rdata_rst", bus.p0_rdata_o, 0);
        check("mid_starve_rst", 32'(dut.starve_cnt), 0);
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_rvalid", i), 32'({bus.p1_rvalid_o, bus.p0_rvalid_o}), 0);
            check($sformatf("post_rst%0d_starve", i), 32'(dut.starve_cnt), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
